mac_stop_matmul: RTL and testbench



---
 rtl/mac_stop_pkg.sv | 22 ++
 rtl/mac_stop_mac_unit.sv | 34 +++
 rtl/mac_stop_matmul.sv | 161 ++++++++++++++++
 tb/tb_mac_stop_matmul.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_stop_pkg.sv
// rtl/mac_stop_pkg.sv - shared FSM state type and default dimensions for mac_stop_matmul
package mac_stop_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEF_M      = 8;
    localparam int DEF_K      = 6;
    localparam int DEF_N      = 4;
    localparam int DEF_DW     = 32;
    localparam int DEF_RW     = 2 * DEF_DW + $clog2(DEF_K);

    // Address width for a dimension; a dimension of one still needs a 1-bit port
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_mac_unit.sv
// rtl/mac_stop_mac_unit.sv - unsigned multiply feeding a clearable accumulator
module mac_stop_mac_unit #(
    parameter int DW = 32,
    parameter int RW = 67
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          en,
    input  logic          clear,
    output logic [RW-1:0] sum
);

    logic [2*DW-1:0] product;
    logic [RW-1:0]   acc;

    // Full-width product, zero-extended so the running sum never wraps
    always_comb begin
        product = a * b;
        sum     = acc + {{(RW-2*DW){1'b0}}, product};
    end

    // Clear wins over accumulate so the last term of a dot product restarts at zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/mac_stop_matmul.sv
// rtl/mac_stop_matmul.sv - single-MAC matrix multiplier C = A x B with host load/read ports
module mac_stop_matmul
    import mac_stop_pkg::*;
#(
    parameter int M                        = DEF_M,
    parameter int K                        = DEF_K,
    parameter int N                        = DEF_N,
    parameter int DATA_WIDTH_INIT_MATRIX   = DEF_DW,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                host2block_val,
    output logic                                host2block_rdy,
    input  logic                                block2host_rdy,
    output logic                                block2host_val,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   ext_data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   ext_data_in_b,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] ext_data_out_c,
    input  logic [addr_w(M)-1:0]                ext_row_addr_a,
    input  logic [addr_w(K)-1:0]                ext_col_addr_a,
    input  logic [addr_w(K)-1:0]                ext_row_addr_b,
    input  logic [addr_w(N)-1:0]                ext_col_addr_b,
    input  logic [addr_w(M)-1:0]                ext_row_addr_c,
    input  logic [addr_w(N)-1:0]                ext_col_addr_c,
    input  logic                                ext_matrix_a_we,
    input  logic                                ext_matrix_b_we,
    input  logic                                ext_matrix_c_re,
    input  logic                                done_sending_data,
    input  logic                                done_reading_result_matrix,
    output logic                                start_reading_result_matrix,
    output logic                                mac_done
);

    localparam int DW = DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;
    localparam int MW = addr_w(M);
    localparam int KW = addr_w(K);
    localparam int NW = addr_w(N);
    localparam logic [MW-1:0] I_LAST = MW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [NW-1:0] J_LAST = NW'(N - 1);

    state_t state, state_next;

    logic [DW-1:0] a_mem [M][K];
    logic [DW-1:0] b_mem [K][N];
    logic [RW-1:0] c_mem [M][N];

    logic [MW-1:0] i_cnt;
    logic [KW-1:0] k_cnt;
    logic [NW-1:0] j_cnt;
    logic          in_compute;
    logic          k_last;
    logic          j_last;
    logic          i_last;
    logic          a_ok;
    logic          b_ok;
    logic          c_ok;
    logic [RW-1:0] mac_sum;

    assign in_compute = (state == COMPUTE);
    assign k_last     = (k_cnt == K_LAST);
    assign j_last     = (j_cnt == J_LAST);
    assign i_last     = (i_cnt == I_LAST);
    assign a_ok       = (int'(ext_row_addr_a) < M) && (int'(ext_col_addr_a) < K);
    assign b_ok       = (int'(ext_row_addr_b) < K) && (int'(ext_col_addr_b) < N);
    assign c_ok       = (int'(ext_row_addr_c) < M) && (int'(ext_col_addr_c) < N);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state: each state reacts only to the one control input that matters to it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (host2block_val)             state_next = SAVE;
            SAVE:    if (done_sending_data)          state_next = COMPUTE;
            COMPUTE: if (k_last && j_last && i_last) state_next = DONE;
            DONE:    if (done_reading_result_matrix) state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // Host-facing handshake and C read mux
    always_comb begin
        host2block_rdy              = (state == IDLE) || (state == SAVE);
        block2host_val              = (state == DONE);
        mac_done                    = (state == DONE);
        start_reading_result_matrix = (state == DONE) && block2host_rdy;
        ext_data_out_c              = '0;
        if ((state == DONE) && ext_matrix_c_re && c_ok)
            ext_data_out_c = c_mem[ext_row_addr_c][ext_col_addr_c];
    end

    // Loop counters: k innermost, then j, then i; held at zero outside COMPUTE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn || !in_compute) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end else if (k_last) begin
            k_cnt <= '0;
            if (j_last) begin
                j_cnt <= '0;
                i_cnt <= i_last ? '0 : i_cnt + 1'b1;
            end else begin
                j_cnt <= j_cnt + 1'b1;
            end
        end else begin
            k_cnt <= k_cnt + 1'b1;
        end
    end

    // A/B operand storage, writable only while loading
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < K; c++)
                    a_mem[r][c] <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < N; c++)
                    b_mem[r][c] <= '0;
        end else if (state == SAVE) begin
            if (ext_matrix_a_we && a_ok)
                a_mem[ext_row_addr_a][ext_col_addr_a] <= ext_data_in_a;
            if (ext_matrix_b_we && b_ok)
                b_mem[ext_row_addr_b][ext_col_addr_b] <= ext_data_in_b;
        end
    end

    // C storage: the finished dot product lands on the last k of each element
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    c_mem[r][c] <= '0;
        end else if (in_compute && k_last) begin
            c_mem[i_cnt][j_cnt] <= mac_sum;
        end
    end

    mac_stop_mac_unit #(
        .DW (DW),
        .RW (RW)
    ) u_mac (
        .clk    (clk),
        .resetn (resetn),
        .a      (a_mem[i_cnt][k_cnt]),
        .b      (b_mem[k_cnt][j_cnt]),
        .en     (in_compute),
        .clear  (!in_compute || k_last),
        .sum    (mac_sum)
    );

endmodule

// File: tb/tb_mac_stop_matmul.sv
// tb/tb_mac_stop_matmul.sv - directed self-checking bench for mac_stop_matmul
module tb_mac_stop_matmul;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        host2block_val = 1'b0;
    logic        host2block_rdy;
    logic        block2host_rdy = 1'b0;
    logic        block2host_val;
    logic [31:0] ext_data_in_a = '0;
    logic [31:0] ext_data_in_b = '0;
    logic [66:0] ext_data_out_c;
    logic [2:0]  ext_row_addr_a = '0;
    logic [2:0]  ext_col_addr_a = '0;
    logic [2:0]  ext_row_addr_b = '0;
    logic [1:0]  ext_col_addr_b = '0;
    logic [2:0]  ext_row_addr_c = '0;
    logic [1:0]  ext_col_addr_c = '0;
    logic        ext_matrix_a_we = 1'b0;
    logic        ext_matrix_b_we = 1'b0;
    logic        ext_matrix_c_re = 1'b0;
    logic        done_sending_data = 1'b0;
    logic        done_reading_result_matrix = 1'b0;
    logic        start_reading_result_matrix;
    logic        mac_done;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mac_stop_matmul dut (
        .clk                         (clk),
        .resetn                      (resetn),
        .host2block_val              (host2block_val),
        .host2block_rdy              (host2block_rdy),
        .block2host_rdy              (block2host_rdy),
        .block2host_val              (block2host_val),
        .ext_data_in_a               (ext_data_in_a),
        .ext_data_in_b               (ext_data_in_b),
        .ext_data_out_c              (ext_data_out_c),
        .ext_row_addr_a              (ext_row_addr_a),
        .ext_col_addr_a              (ext_col_addr_a),
        .ext_row_addr_b              (ext_row_addr_b),
        .ext_col_addr_b              (ext_col_addr_b),
        .ext_row_addr_c              (ext_row_addr_c),
        .ext_col_addr_c              (ext_col_addr_c),
        .ext_matrix_a_we             (ext_matrix_a_we),
        .ext_matrix_b_we             (ext_matrix_b_we),
        .ext_matrix_c_re             (ext_matrix_c_re),
        .done_sending_data           (done_sending_data),
        .done_reading_result_matrix  (done_reading_result_matrix),
        .start_reading_result_matrix (start_reading_result_matrix),
        .mac_done                    (mac_done)
    );

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input int r, input int c, input logic [31:0] d);
        ext_row_addr_a  = 3'(r);
        ext_col_addr_a  = 3'(c);
        ext_data_in_a   = d;
        ext_matrix_a_we = 1'b1;
        step();
        ext_matrix_a_we = 1'b0;
    endtask

    task automatic wr_b(input int r, input int c, input logic [31:0] d);
        ext_row_addr_b  = 3'(r);
        ext_col_addr_b  = 2'(c);
        ext_data_in_b   = d;
        ext_matrix_b_we = 1'b1;
        step();
        ext_matrix_b_we = 1'b0;
    endtask

    task automatic rd_c(input int r, input int c, output logic [66:0] d);
        ext_row_addr_c  = 3'(r);
        ext_col_addr_c  = 2'(c);
        ext_matrix_c_re = 1'b1;
        #1;
        d = ext_data_out_c;
        ext_matrix_c_re = 1'b0;
    endtask

    // Enter SAVE from IDLE
    task automatic open_save();
        host2block_val = 1'b1;
        step();
        host2block_val = 1'b0;
    endtask

    // Called one cycle after COMPUTE was entered; counts edges until DONE
    task automatic wait_done(input string tag);
        int cnt;
        cnt = 0;
        chk({tag, "_rdy_in_compute"}, 67'(host2block_rdy), 67'd0);
        while (!mac_done && cnt < 1000) begin
            step();
            cnt++;
        end
        chk({tag, "_latency"}, 67'(cnt), 67'd192);
    endtask

    task automatic leave_done();
        done_reading_result_matrix = 1'b1;
        step();
        done_reading_result_matrix = 1'b0;
    endtask

    logic [66:0] rd;
    logic [66:0] big;
    int          row_exp1 [8] = '{168, 252, 336, 420, 504, 588, 672, 756};
    int          row_exp2 [8] = '{24, 36, 48, 60, 72, 84, 96, 108};

    initial begin
        big = 67'd6 * (67'h0FFFFFFFF * 67'h0FFFFFFFF);

        // Reset state
        step();
        chk("rst_h2b_rdy", 67'(host2block_rdy), 67'd1);
        chk("rst_b2h_val", 67'(block2host_val), 67'd0);
        chk("rst_mac_done", 67'(mac_done), 67'd0);
        resetn = 1'b1;
        step();
        chk("idle_h2b_rdy", 67'(host2block_rdy), 67'd1);
        chk("idle_c_out", ext_data_out_c, 67'd0);

        // Pass 1: A row i = 4+2i, B row k = 2+2k
        open_save();
        chk("save_h2b_rdy", 67'(host2block_rdy), 67'd1);
        chk("save_mac_done", 67'(mac_done), 67'd0);
        chk("save_start_rd", 67'(start_reading_result_matrix), 67'd0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 6; k++)
                wr_a(i, k, 32'(4 + 2 * i));
        // Out-of-range writes must not disturb anything
        wr_a(0, 6, 32'd999);
        wr_b(7, 0, 32'd999);
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < 4; j++) begin
                if (k == 5 && j == 3) done_sending_data = 1'b1;
                wr_b(k, j, 32'(2 + 2 * k));
            end
        done_sending_data = 1'b0;
        wait_done("p1");

        chk("done_b2h_val", 67'(block2host_val), 67'd1);
        chk("done_start_rd_lo", 67'(start_reading_result_matrix), 67'd0);
        block2host_rdy = 1'b1;
        #1;
        chk("done_start_rd_hi", 67'(start_reading_result_matrix), 67'd1);
        ext_row_addr_c = 3'd3;
        ext_col_addr_c = 2'd1;
        #1;
        chk("c_out_no_re", ext_data_out_c, 67'd0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) begin
                rd_c(i, j, rd);
                chk($sformatf("p1_c%0d%0d", i, j), rd, 67'(row_exp1[i]));
            end
        block2host_rdy = 1'b0;
        leave_done();
        chk("idle_mac_done", 67'(mac_done), 67'd0);
        chk("idle_b2h_val", 67'(block2host_val), 67'd0);
        chk("idle_h2b_rdy2", 67'(host2block_rdy), 67'd1);

        // Writes in IDLE are ignored; pass 2 rewrites only B (all ones), A retained
        for (int k = 0; k < 6; k++)
            wr_a(0, k, 32'd100);
        open_save();
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < 4; j++)
                wr_b(k, j, 32'd1);
        done_sending_data = 1'b1;
        step();
        done_sending_data = 1'b0;
        wait_done("p2");
        for (int i = 0; i < 8; i++) begin
            rd_c(i, i % 4, rd);
            chk($sformatf("p2_c%0d", i), rd, 67'(row_exp2[i]));
        end
        leave_done();

        // Pass 3: all-ones operands, concurrent A and B writes
        open_save();
        for (int idx = 0; idx < 48; idx++) begin
            if (idx < 24) begin
                ext_row_addr_b  = 3'(idx / 4);
                ext_col_addr_b  = 2'(idx % 4);
                ext_data_in_b   = 32'hFFFFFFFF;
                ext_matrix_b_we = 1'b1;
            end
            wr_a(idx / 6, idx % 6, 32'hFFFFFFFF);
            ext_matrix_b_we = 1'b0;
        end
        done_sending_data = 1'b1;
        step();
        done_sending_data = 1'b0;
        wait_done("p3");
        rd_c(0, 0, rd);
        chk("max_c00", rd, big);
        rd_c(7, 3, rd);
        chk("max_c73", rd, big);
        rd_c(4, 2, rd);
        chk("max_c42", rd, big);
        leave_done();

        // Reset mid-compute aborts straight back to IDLE
        open_save();
        done_sending_data = 1'b1;
        step();
        done_sending_data = 1'b0;
        for (int n = 0; n < 50; n++) step();
        chk("mid_rdy_busy", 67'(host2block_rdy), 67'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_h2b_rdy", 67'(host2block_rdy), 67'd1);
        chk("abort_mac_done", 67'(mac_done), 67'd0);
        chk("abort_b2h_val", 67'(block2host_val), 67'd0);
        step();
        resetn = 1'b1;
        step();
        // B was cleared by the reset, so a pass loading only A yields all-zero C
        open_save();
        for (int k = 0; k < 6; k++)
            wr_a(2, k, 32'd7);
        done_sending_data = 1'b1;
        step();
        done_sending_data = 1'b0;
        wait_done("p4");
        rd_c(2, 0, rd);
        chk("abort_c20", rd, 67'd0);
        rd_c(7, 3, rd);
        chk("abort_c73", rd, 67'd0);
        leave_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
